flag_condition_sequencer: RTL
=============================

Name: flag_condition_sequencer

Overview:
- Downstream consumer of the flag register F.
- Evaluates Z80 condition codes and block-repeat/DJNZ termination from a sampled copy of F and the B-zero status.
- Produces the taken/rewind decision for the PC/microcode sequencer and stalls it for the extra T-states a taken branch or repeat costs.
- Sits between the F register outputs and the instruction sequencer.

Parameters:
- JR_EXTRA, 5, extra cycles for a taken JR cc / JR e.
- DJNZ_EXTRA, 5, extra cycles for a taken DJNZ.
- CALL_EXTRA, 7, extra cycles for a taken CALL cc.
- RET_EXTRA, 6, extra cycles for a taken RET cc.
- BLK_EXTRA, 5, extra cycles for a repeating block instruction.
- CNT_W, 3, width of the extra-cycle counter; must hold the largest *_EXTRA value.

Ports:
- Clk  in  1  system clock, rising edge.
- notReset  in  1  asynchronous active-low reset.
- Start  in  1  request pulse; accepted only when Busy=0.
- Kind  in  3  0 JP, 1 JR, 2 CALL, 3 RET, 4 DJNZ, 5 BLK_LD, 6 BLK_CP, 7 BLK_IO.
- Cond  in  3  Z80 cc: 0 NZ, 1 Z, 2 NC, 3 C, 4 PO, 5 PE, 6 P, 7 M.
- Uncond  in  1  unconditional form; forces condition true (JP/JR/CALL/RET only).
- F  in  8  flag register: [7]S [6]Z [4]H [2]PV [1]N [0]C.
- BZero  in  1  B register after decrement == 0.
- Flush  in  1  synchronous abort: back to IDLE, no Done.
- Busy  out  1  high from the cycle after acceptance until Done.
- Stall  out  1  high during extra-cycle countdown.
- Done  out  1  one-cycle completion pulse.
- Taken  out  1  decision; valid from Done, held until the next accepted Start.
- Rewind  out  1  block repeat: sequencer sets PC -= 2; held like Taken.

Behaviour:
- Reset: async when notReset=0. State IDLE; Busy, Stall, Done, Taken, Rewind, counter and captured regs = 0.
- Capture: on an accepted Start, register Kind, Cond, Uncond, F and BZero. Later changes to F are ignored; the flags written by the block op itself must already be in F.
- Condition:
  - NZ = !Z, Z = Z, NC = !C, C = C, PO = !PV, PE = PV, P = !S, M = S.
  - JR uses Cond[1:0] only (cc 0-3); Cond[2] is ignored.
  - DJNZ taken = !BZero.
  - BLK_LD repeat = PV.
  - BLK_CP repeat = PV & !Z.
  - BLK_IO repeat = !Z.
  - Block kinds drive Rewind = repeat and Taken = repeat. Non-block kinds drive Rewind = 0.
  - Uncond is ignored for DJNZ and block kinds.
- FSM:
  - IDLE: on Start & !Flush, go to EVAL.
  - EVAL (1 cycle): compute the decision into Taken/Rewind. Extra = kind extra if taken else 0; JP extra is always 0. If extra = 0, go to DONE; else load counter = extra and go to WAIT.
  - WAIT: Stall = 1; counter decrements each cycle; when counter = 1, go to DONE.
  - DONE: Done = 1 for one cycle, then go to IDLE.
- Latency (Start accepted at cycle n): EVAL at n+1; Done at n+2 when extra = 0; otherwise Stall for cycles n+2 .. n+1+extra and Done at n+2+extra.
- Busy = state != IDLE. Start while Busy is ignored with no side effects.
- Start is accepted in the DONE cycle only if state is already IDLE; i.e. it is not accepted, and the minimum issue interval is 3 cycles.
- Flush: priority over everything. Next state IDLE, Stall/Done = 0, Taken/Rewind keep previous values. Flush together with Start: Start is dropped.
- Reset mid-operation returns to IDLE immediately, and all outputs clear.

Decomposition:
- Shared package (flag_cond_pkg):
  - Kind encodings.
  - cc encodings.
  - F bit indices: S=7, Z=6, H=4, PV=2, N=1, C=0.
  - Default extra-cycle constants.
  - FSM state enum: IDLE, EVAL, WAIT, DONE.
- One combinational sub-module, flag_cond_mux: inputs captured F, Cond, Kind, Uncond, BZero; outputs cond_true and repeat.
- The sequencer instantiates it once and owns the FSM and counter.

Test Plan:
- JP Z with F = 0x40, Uncond = 0, Start at cycle 0 -> Taken = 1, Rewind = 0, Stall never high, Done at cycle 2.
- JR NC with F = 0x01 -> Taken = 0, Done at cycle 2. Same with F = 0x00 -> Taken = 1, Stall high cycles 2-6, Done at cycle 7.
- CPIR (Kind = 6) with F = 0x04 -> Rewind = 1, 5 stall cycles, Done at cycle 7. With F = 0x44 -> Rewind = 0, Done at cycle 2. With F = 0x00 -> Rewind = 0.
- DJNZ with BZero = 0 -> Taken = 1, Done at cycle 7. Then BZero = 1 -> Taken = 0, Done 2 cycles after Start. Also: change F during EVAL/WAIT -> no effect on the decision.
- CALL M with F = 0x80 and Flush asserted at cycle 4 -> Stall drops at cycle 5, no Done pulse, Busy = 0 at cycle 5. Also: Start during Busy is ignored.
- notReset pulled low mid-WAIT, asynchronously between clock edges -> all outputs 0 immediately. After release, a new Start is accepted normally.

Source files
------------

// File: rtl/flag_cond_pkg.sv
// Shared definitions for the flag condition sequencer.
//   - instruction kind and Z80 cc encodings
//   - bit positions inside the F register
//   - default extra T-state counts for taken branches / repeats
//   - sequencer state encodings
//   - cc_eval: evaluates a 3-bit cc against an F value
package flag_cond_pkg;

   localparam logic [2:0] K_JP     = 3'd0;
   localparam logic [2:0] K_JR     = 3'd1;
   localparam logic [2:0] K_CALL   = 3'd2;
   localparam logic [2:0] K_RET    = 3'd3;
   localparam logic [2:0] K_DJNZ   = 3'd4;
   localparam logic [2:0] K_BLK_LD = 3'd5;
   localparam logic [2:0] K_BLK_CP = 3'd6;
   localparam logic [2:0] K_BLK_IO = 3'd7;

   localparam logic [2:0] CC_NZ = 3'd0;
   localparam logic [2:0] CC_Z  = 3'd1;
   localparam logic [2:0] CC_NC = 3'd2;
   localparam logic [2:0] CC_C  = 3'd3;
   localparam logic [2:0] CC_PO = 3'd4;
   localparam logic [2:0] CC_PE = 3'd5;
   localparam logic [2:0] CC_P  = 3'd6;
   localparam logic [2:0] CC_M  = 3'd7;

   localparam int F_S  = 7;
   localparam int F_Z  = 6;
   localparam int F_H  = 4;
   localparam int F_PV = 2;
   localparam int F_N  = 1;
   localparam int F_C  = 0;

   localparam int DEF_JR_EXTRA   = 5;
   localparam int DEF_DJNZ_EXTRA = 5;
   localparam int DEF_CALL_EXTRA = 7;
   localparam int DEF_RET_EXTRA  = 6;
   localparam int DEF_BLK_EXTRA  = 5;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EVAL = 2'd1;
   localparam state_t ST_WAIT = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   function automatic logic cc_eval(input logic [7:0] f, input logic [2:0] cc);
      logic res;
      case (cc)
         CC_NZ:   res = ~f[F_Z];
         CC_Z:    res =  f[F_Z];
         CC_NC:   res = ~f[F_C];
         CC_C:    res =  f[F_C];
         CC_PO:   res = ~f[F_PV];
         CC_PE:   res =  f[F_PV];
         CC_P:    res = ~f[F_S];
         default: res =  f[F_S];
      endcase
      return res;
   endfunction

endpackage

// File: rtl/flag_cond_mux.sv
// Combinational decision logic on the captured operands.
//   f, cond, kind, uncond, bzero : captured request
//   cond_true : branch condition for JP/JR/CALL/RET/DJNZ (0 for block kinds)
//   repeat_op : repeat decision for block kinds (0 otherwise)
module flag_cond_mux
   import flag_cond_pkg::*;
(
   input  logic [7:0] f,
   input  logic [2:0] cond,
   input  logic [2:0] kind,
   input  logic       uncond,
   input  logic       bzero,
   output logic       cond_true,
   output logic       repeat_op
);

   logic [2:0] cc;
   logic       cc_true;
   logic       unused_bits;

   // JR only encodes NZ/Z/NC/C
   assign cc      = (kind == K_JR) ? {1'b0, cond[1:0]} : cond;
   assign cc_true = cc_eval(f, cc);

   // H and N do not influence any decision
   assign unused_bits = ^{f[5:3], f[1]};

   always_comb begin
      cond_true = 1'b0;
      repeat_op = 1'b0;
      case (kind)
         K_JP, K_JR, K_CALL, K_RET: cond_true = uncond | cc_true;
         K_DJNZ:                    cond_true = ~bzero;
         K_BLK_LD:                  repeat_op = f[F_PV];
         K_BLK_CP:                  repeat_op = f[F_PV] & ~f[F_Z];
         default:                   repeat_op = ~f[F_Z];
      endcase
   end

endmodule

// File: rtl/flag_condition_sequencer.sv
// Branch / block-repeat decision sequencer between the F register and the
// instruction sequencer. Captures a request, decides taken/rewind, and stalls
// the sequencer for the extra T-states a taken branch or repeat costs.
//   Clk, notReset       : clock, async active-low reset
//   Start, Kind, Cond,
//   Uncond, F, BZero    : request and operands (captured on acceptance)
//   Flush               : synchronous abort
//   Busy, Stall, Done   : handshake / stall to the sequencer
//   Taken, Rewind       : decision, held until overwritten by a later EVAL
//
// state   | meaning
// IDLE    | waiting for Start
// EVAL    | decision computed from captured operands
// WAIT    | Stall high, extra-cycle down-counter running
// DONE    | one-cycle Done pulse
module flag_condition_sequencer
   import flag_cond_pkg::*;
#(
   parameter int JR_EXTRA   = DEF_JR_EXTRA,
   parameter int DJNZ_EXTRA = DEF_DJNZ_EXTRA,
   parameter int CALL_EXTRA = DEF_CALL_EXTRA,
   parameter int RET_EXTRA  = DEF_RET_EXTRA,
   parameter int BLK_EXTRA  = DEF_BLK_EXTRA,
   parameter int CNT_W      = 3
) (
   input  logic       Clk,
   input  logic       notReset,
   input  logic       Start,
   input  logic [2:0] Kind,
   input  logic [2:0] Cond,
   input  logic       Uncond,
   input  logic [7:0] F,
   input  logic       BZero,
   input  logic       Flush,
   output logic       Busy,
   output logic       Stall,
   output logic       Done,
   output logic       Taken,
   output logic       Rewind
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         kind_q;
   logic [2:0]         cond_q;
   logic               uncond_q;
   logic [7:0]         f_q;
   logic               bzero_q;

   logic               cond_true;
   logic               repeat_op;
   logic               is_blk;
   logic               taken_d;
   logic [CNT_W-1:0]   extra;

   flag_cond_mux u_mux (
      .f         (f_q),
      .cond      (cond_q),
      .kind      (kind_q),
      .uncond    (uncond_q),
      .bzero     (bzero_q),
      .cond_true (cond_true),
      .repeat_op (repeat_op)
   );

   assign is_blk  = (kind_q == K_BLK_LD) || (kind_q == K_BLK_CP) || (kind_q == K_BLK_IO);
   assign taken_d = is_blk ? repeat_op : cond_true;

   always_comb begin
      extra = '0;
      if (taken_d) begin
         case (kind_q)
            K_JR:    extra = CNT_W'(JR_EXTRA);
            K_CALL:  extra = CNT_W'(CALL_EXTRA);
            K_RET:   extra = CNT_W'(RET_EXTRA);
            K_DJNZ:  extra = CNT_W'(DJNZ_EXTRA);
            K_JP:    extra = '0;
            default: extra = CNT_W'(BLK_EXTRA);
         endcase
      end
   end

   always_ff @(posedge Clk or negedge notReset) begin
      if (!notReset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         kind_q   <= '0;
         cond_q   <= '0;
         uncond_q <= 1'b0;
         f_q      <= '0;
         bzero_q  <= 1'b0;
         Taken    <= 1'b0;
         Rewind   <= 1'b0;
      end else if (Flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  kind_q   <= Kind;
                  cond_q   <= Cond;
                  uncond_q <= Uncond;
                  f_q      <= F;
                  bzero_q  <= BZero;
                  state    <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               Taken  <= taken_d;
               Rewind <= is_blk & repeat_op;
               if (extra == '0) begin
                  state <= ST_DONE;
               end else begin
                  cnt   <= extra;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign Busy  = (state != ST_IDLE);
   assign Stall = (state == ST_WAIT);
   assign Done  = (state == ST_DONE);

endmodule
